// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 encodings and reader state type
package axi4_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    SEND_AR,
    RECV
  } state_t;

endpackage

// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - AXI4-Full bus bundle with master/slave modports
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_full_reader.sv
// rtl/axi4_full_reader.sv - AXI4 burst read master feeding a downstream FIFO
module axi4_full_reader
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 16,
  parameter int AR_ID      = 0,
  parameter int FREE_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  num_bursts,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [FREE_WIDTH-1:0] fifo_free,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  axi4_if.master                axi4_master_if
);

  localparam int                    BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = ~(ADDR_WIDTH'(BURST_BYTES - 1));
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [2:0]            AR_SIZE     = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ID_WIDTH-1:0]   AR_ID_VEC   = ID_WIDTH'(AR_ID);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_WIDTH-1:0]  bursts_left_q, bursts_left_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic rready;
  logic r_hs;
  logic last_beat;

  // R acceptance is a pure function of state so reset drops it at once
  assign rready    = (state_q == RECV) && !fifo_full;
  assign r_hs      = rready && axi4_master_if.rvalid;
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  // Next-state, address/burst bookkeeping and sticky error detection
  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    bursts_left_d = bursts_left_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d     = start_addr & ADDR_MASK;
          bursts_left_d = num_bursts;
          err_d         = 1'b0;
          if (num_bursts == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        // Reserve room for a whole burst before asking for it
        if (fifo_free >= FREE_WIDTH'(BURST_LEN)) begin
          state_d = SEND_AR;
        end
      end
      SEND_AR: begin
        if (axi4_master_if.arready) begin
          state_d    = RECV;
          beat_cnt_d = 8'd0;
        end
      end
      RECV: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if ((axi4_master_if.rresp != RESP_OKAY) ||
              (axi4_master_if.rid != AR_ID_VEC) ||
              (axi4_master_if.rlast != last_beat)) begin
            err_d = 1'b1;
          end
          // Burst ends on our own beat count, not on RLAST
          if (last_beat) begin
            rd_addr_d     = rd_addr_q + ADDR_STEP;
            bursts_left_d = bursts_left_q - CNT_WIDTH'(1);
            if (bursts_left_q == CNT_WIDTH'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT_SPACE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      bursts_left_q <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      bursts_left_q <= bursts_left_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign fifo_wr_en = r_hs;
  assign fifo_wdata = axi4_master_if.rdata;

  assign axi4_master_if.arid    = AR_ID_VEC;
  assign axi4_master_if.araddr  = rd_addr_q;
  assign axi4_master_if.arlen   = LAST_BEAT;
  assign axi4_master_if.arsize  = AR_SIZE;
  assign axi4_master_if.arburst = BURST_INCR;
  assign axi4_master_if.arprot  = 3'b000;
  assign axi4_master_if.arvalid = (state_q == SEND_AR);
  assign axi4_master_if.rready  = rready;

  // Write direction is unused by a reader
  assign axi4_master_if.awid    = '0;
  assign axi4_master_if.awaddr  = '0;
  assign axi4_master_if.awlen   = '0;
  assign axi4_master_if.awsize  = '0;
  assign axi4_master_if.awburst = '0;
  assign axi4_master_if.awvalid = 1'b0;
  assign axi4_master_if.wdata   = '0;
  assign axi4_master_if.wstrb   = '0;
  assign axi4_master_if.wlast   = 1'b0;
  assign axi4_master_if.wvalid  = 1'b0;
  assign axi4_master_if.bready  = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, axi4_master_if.awready, axi4_master_if.wready,
                       axi4_master_if.bid, axi4_master_if.bresp, axi4_master_if.bvalid};

endmodule
